// File: rtl/lf_prefix_sum128.sv
// 128-lane inclusive prefix popcount of a flag mask, Ladner-Fischer network,
// one registered output stage (1-cycle latency, full throughput).
module lf_prefix_sum128 (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [127:0]    mask,
  output logic [1023:0]   psum
);

  logic [1023:0] psum_next;

  // Level k consumes (k+1)-bit lane sums and produces (k+2)-bit lane sums;
  // each level is its own block so the widths grow with the sum range.
  for (genvar k = 0; k < 7; k++) begin : g_lvl
    localparam int IW  = k + 1;
    localparam int OW  = k + 2;
    localparam int BLK = 1 << k;

    logic [128*IW-1:0] din;
    logic [128*OW-1:0] s;

    if (k == 0) begin : g_leaf
      assign din = mask;
    end else begin : g_chain
      assign din = g_lvl[k-1].s;
    end

    for (genvar i = 0; i < 128; i++) begin : g_lane
      // Lanes in an odd-numbered block pick up the running sum of the
      // last lane of the block just below them.
      if (((i / BLK) % 2) == 1) begin : g_add
        localparam int SRC = (i / BLK) * BLK - 1;
        assign s[i*OW +: OW] = {1'b0, din[i*IW +: IW]} + {1'b0, din[SRC*IW +: IW]};
      end else begin : g_pass
        assign s[i*OW +: OW] = {1'b0, din[i*IW +: IW]};
      end
    end
  end

  assign psum_next = g_lvl[6].s;

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples its inputs from before the edge, independent of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) psum <= '0;
    else          psum <= psum_next;
  end

endmodule

// File: tb/tb_lf_prefix_sum128.sv
// Directed-vector and random back-to-back bench for lf_prefix_sum128,
// checked against a serial running-count reference.
module tb_lf_prefix_sum128;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [127:0]  mask = '0;
  logic [1023:0] psum;

  int n_vec  = 0;
  int n_fail = 0;

  lf_prefix_sum128 dut (
    .clk     (clk),
    .reset_n (reset_n),
    .mask    (mask),
    .psum    (psum)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [127:0] mask;
    int           lane;
    logic [7:0]   exp;
  } vec_t;

  function automatic logic [1023:0] ref_psum(input logic [127:0] m);
    logic [1023:0] r;
    logic [7:0]    c;
    c = 8'd0;
    r = '0;
    for (int i = 0; i < 128; i++) begin
      c = c + {7'd0, m[i]};
      r[i*8 +: 8] = c;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%02h), expected %0d (0x%02h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      for (int i = 0; i < 128; i++) begin
        if (act[i*8 +: 8] !== exp[i*8 +: 8]) begin
          $display("FAIL %s: first bad lane %0d got 0x%02h, expected 0x%02h",
                   name, i, act[i*8 +: 8], exp[i*8 +: 8]);
          break;
        end
      end
    end
  endtask

  task automatic apply(input logic [127:0] m);
    @(negedge clk);
    mask = m;
    @(posedge clk);
    #1;
  endtask

  vec_t         vecs[$];
  logic [127:0] m_rep, m_zero, m_b0, m_b127, m_ones, prev, nxt;

  initial begin
    m_rep  = {4{32'h0808_2013}};
    m_zero = '0;
    m_b0   = 128'd1;
    m_b127 = 128'd1 << 127;
    m_ones = '1;

    vecs.push_back('{"rep lane0",    m_rep,  0,   8'd1});
    vecs.push_back('{"rep lane1",    m_rep,  1,   8'd2});
    vecs.push_back('{"rep lane3",    m_rep,  3,   8'd2});
    vecs.push_back('{"rep lane4",    m_rep,  4,   8'd3});
    vecs.push_back('{"rep lane31",   m_rep,  31,  8'd6});
    vecs.push_back('{"rep lane32",   m_rep,  32,  8'd7});
    vecs.push_back('{"rep lane63",   m_rep,  63,  8'd12});
    vecs.push_back('{"rep lane127",  m_rep,  127, 8'd24});
    vecs.push_back('{"zero lane0",   m_zero, 0,   8'd0});
    vecs.push_back('{"zero lane64",  m_zero, 64,  8'd0});
    vecs.push_back('{"zero lane127", m_zero, 127, 8'd0});
    vecs.push_back('{"bit0 lane0",   m_b0,   0,   8'd1});
    vecs.push_back('{"bit0 lane50",  m_b0,   50,  8'd1});
    vecs.push_back('{"bit0 lane127", m_b0,   127, 8'd1});
    vecs.push_back('{"b127 lane126", m_b127, 126, 8'd0});
    vecs.push_back('{"b127 lane127", m_b127, 127, 8'd1});
    vecs.push_back('{"ones lane0",   m_ones, 0,   8'd1});
    vecs.push_back('{"ones lane127", m_ones, 127, 8'h80});

    // Power-on reset: output is zero with clocks running.
    mask = m_ones;
    repeat (2) @(posedge clk);
    #1;
    check_vec("reset hold", psum, '0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("first edge after reset lane127", psum[127*8 +: 8], 8'h80);

    foreach (vecs[v]) begin
      apply(vecs[v].mask);
      check(vecs[v].name, psum[vecs[v].lane*8 +: 8], vecs[v].exp);
    end

    apply(m_ones);
    for (int i = 0; i < 128; i++)
      check($sformatf("ones lane%0d", i), psum[i*8 +: 8], 8'(i + 1));

    // Asynchronous reset pulsed between edges clears at once and holds.
    apply(m_rep);
    #2;
    reset_n = 1'b0;
    #1;
    check_vec("async reset immediate", psum, '0);
    mask = m_ones;
    repeat (2) @(posedge clk);
    #1;
    check_vec("reset held over edges", psum, '0);
    @(negedge clk);
    reset_n = 1'b1;
    mask = m_rep;
    #1;
    check_vec("released before edge", psum, '0);
    @(posedge clk);
    #1;
    check_vec("first load after release", psum, ref_psum(m_rep));

    // Random masks back-to-back, one per cycle.
    @(negedge clk);
    prev = {$urandom, $urandom, $urandom, $urandom};
    mask = prev;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      check_vec($sformatf("random %0d", n), psum, ref_psum(prev));
      nxt = {$urandom, $urandom, $urandom, $urandom};
      mask = nxt;
      prev = nxt;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
